ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter, the sending end of the keyboard link whose

---
 rtl/ps2_host_tx_if.sv | 32 +++
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: byte request handshake plus the
// open-collector pad controls and raw pad levels.
//
// Handshake: a byte is accepted on a clk edge where tx_valid & tx_ready.
// tx_ready is high only while the transmitter is idle. tx_valid seen while
// busy is ignored, not queued, and tx_data need only be stable on the
// accepting edge.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       ps2_busy;
    logic       tx_done;
    logic       tx_error;

    // Requesting side: supplies bytes, watches status, and also
    // represents the pads.
    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, ps2_busy, tx_done, tx_error
    );

    // Transmitter side.
    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, ps2_busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// The FSM steps through these phases:
//   1. Inhibit the clock, then assert request-to-send.
//   2. Drive start/data/parity/stop on device clock falls.
//   3. Check the device ACK and wait for the bus to go idle.
// Pads are open collector: an oe of 1 pulls the line low.
module ps2_host_tx #(
    parameter int CLK_HZ     = 25000000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 15000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    output logic [2:0]   dbg_state_o
);
    localparam int CYC_PER_US  = CLK_HZ / 1000000;
    localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_RTS, ST_DATA,
        ST_ACK, ST_WAIT_IDLE, ST_DONE, ST_ERROR
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic             clk_oe_q, data_oe_q, done_q, error_q;

    logic [1:0] clk_sync_q, data_sync_q;
    logic [2:0] clk_hist_q, data_hist_q;
    logic       clk_filt_q, data_filt_q, fall_q;
    logic       clk_filt_d, data_filt_d, fall_d;

    // A filtered level flips only after four consecutive equal synchronized samples.
    always_comb begin
        clk_filt_d  = clk_filt_q;
        data_filt_d = data_filt_q;
        if (&{clk_sync_q[1], clk_hist_q})
            clk_filt_d = 1'b1;
        else if (~|{clk_sync_q[1], clk_hist_q})
            clk_filt_d = 1'b0;
        if (&{data_sync_q[1], data_hist_q})
            data_filt_d = 1'b1;
        else if (~|{data_sync_q[1], data_hist_q})
            data_filt_d = 1'b0;
        fall_d = clk_filt_q & ~clk_filt_d;
    end

    // Pad synchronizers, sample history and filtered levels; the idle bus reads high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_hist_q  <= 3'b111;
            data_hist_q <= 3'b111;
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_i};
            data_sync_q <= {data_sync_q[0], bus.ps2_data_i};
            clk_hist_q  <= {clk_hist_q[1:0], clk_sync_q[1]};
            data_hist_q <= {data_hist_q[1:0], data_sync_q[1]};
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
            fall_q      <= fall_d;
        end
    end

    // Transmit sequencer; the oe lines and the done/error pulses are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    bit_cnt_q <= '0;
                    if (bus.tx_valid) begin
                        shift_q  <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        cnt_q    <= INHIBIT_LOAD;
                        clk_oe_q <= 1'b1;
                        state_q  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_q == '0) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        state_q   <= ST_RTS;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        // Data goes low during the final inhibit cycle.
                        if (cnt_q == CNT_W'(1))
                            data_oe_q <= 1'b1;
                    end
                end
                ST_RTS: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b1;
                    cnt_q     <= TIMEOUT_LOAD;
                    state_q   <= ST_DATA;
                end
                ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
                    // An expired timeout wins over a clock fall in the same cycle.
                    if (cnt_q == '0) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= ST_ERROR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (state_q == ST_DATA) begin
                            if (fall_q) begin
                                data_oe_q <= ~shift_q[0];
                                shift_q   <= {1'b0, shift_q[9:1]};
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                if (bit_cnt_q == 4'd9)
                                    state_q <= ST_ACK;
                            end
                        end else if (state_q == ST_ACK) begin
                            if (fall_q) begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                if (data_filt_q) begin
                                    data_oe_q <= 1'b0;
                                    error_q   <= 1'b1;
                                    state_q   <= ST_ERROR;
                                end else begin
                                    state_q <= ST_WAIT_IDLE;
                                end
                            end
                        end else if (clk_filt_q && data_filt_q) begin
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERROR: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = (state_q == ST_IDLE);
    assign bus.ps2_busy    = (state_q != ST_IDLE);
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_error    = error_q;
    assign dbg_state_o     = state_q;
endmodule
